// File: rtl/l1_icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_types
// Shared types and constants for the L1 instruction cache.
//   - Default field widths of the cache address split (offset/index/tag).
//   - Fill line width (256 bits = 8 x 32-bit words).
//   - FSM state encoding (IDLE, FETCH), kept as plain localparam constants so
//     older tools and existing decode logic can compare against them directly.
// -----------------------------------------------------------------------------
package icache_types;

  localparam int ICACHE_S_OFFSET   = 5;
  localparam int ICACHE_S_INDEX    = 4;
  localparam int ICACHE_S_TAG      = 32 - ICACHE_S_INDEX - ICACHE_S_OFFSET;
  localparam int ICACHE_NUM_SETS   = 1 << ICACHE_S_INDEX;
  localparam int ICACHE_WORD_SEL_W = ICACHE_S_OFFSET - 2;

  localparam int LINE_WIDTH = 256;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t FETCH = 1'b1;

endpackage

// File: rtl/l1_icache_way.sv
// -----------------------------------------------------------------------------
// l1_icache_way
// One way of the two-way L1 instruction cache: line data, tag and valid
// arrays. All arrays are read asynchronously and written on the clock edge.
// Only the valid bits are reset; data and tag are qualified by valid.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (clears valid bits)
//   rd_index    set index of the current lookup
//   rd_data     line data of rd_index
//   rd_tag      tag of rd_index
//   rd_valid    valid bit of rd_index
//   fill_index  set index being filled
//   fill_en     write fill_data/fill_tag and set valid at fill_index
//   fill_tag    tag written on a fill
//   fill_data   line written on a fill
//   fill_valid  valid bit of fill_index (used for victim choice)
// -----------------------------------------------------------------------------
module l1_icache_way
  import icache_types::*;
#(
  parameter int S_INDEX = ICACHE_S_INDEX,
  parameter int S_TAG   = ICACHE_S_TAG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_INDEX-1:0]    rd_index,
  output logic [LINE_WIDTH-1:0] rd_data,
  output logic [S_TAG-1:0]      rd_tag,
  output logic                  rd_valid,
  input  logic [S_INDEX-1:0]    fill_index,
  input  logic                  fill_en,
  input  logic [S_TAG-1:0]      fill_tag,
  input  logic [LINE_WIDTH-1:0] fill_data,
  output logic                  fill_valid
);

  localparam int NUM_SETS = 1 << S_INDEX;

  logic [LINE_WIDTH-1:0] data_r  [NUM_SETS];
  logic [S_TAG-1:0]      tag_r   [NUM_SETS];
  logic [NUM_SETS-1:0]   valid_r;

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else if (fill_en) begin
      valid_r[fill_index] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data and tag storage, written only on a fill.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_r[fill_index] <= fill_data;
      tag_r[fill_index]  <= fill_tag;
    end
  end

  assign rd_data    = data_r[rd_index];
  assign rd_tag     = tag_r[rd_index];
  assign rd_valid   = valid_r[rd_index];
  assign fill_valid = valid_r[fill_index];

endmodule

// File: rtl/l1_icache.sv
// -----------------------------------------------------------------------------
// l1_icache
// Two-way set-associative, read-only L1 instruction cache. Hits answer in the
// same cycle as the request; a miss moves to FETCH, requests the whole
// 256-bit line from L2, writes it into the victim way and returns to IDLE,
// where the retried request then hits.
//
// Optional build macro: ICACHE_STATS_EN adds saturating hit_count/miss_count.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   mem_read      fetch request
//   mem_address   fetch byte address (word aligned)
//   mem_rdata     instruction word (zero when not responding)
//   mem_resp      request serviced this cycle
//   pmem_read     line fill request to L2
//   pmem_address  line-aligned fill address (zero when not fetching)
//   pmem_rdata    fill line data
//   pmem_resp     fill complete, pmem_rdata valid
//   hit_count     (ICACHE_STATS_EN) IDLE cycles with mem_read and a hit
//   miss_count    (ICACHE_STATS_EN) IDLE-to-FETCH transitions
// -----------------------------------------------------------------------------
module l1_icache
  import icache_types::*;
#(
  parameter int S_OFFSET = ICACHE_S_OFFSET,
  parameter int S_INDEX  = ICACHE_S_INDEX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic [31:0]           mem_address,
  output logic [31:0]           mem_rdata,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int WSEL_W   = S_OFFSET - 2;

  // Request address split
  logic [S_TAG-1:0]   req_tag_s;
  logic [S_INDEX-1:0] req_index_s;
  logic [WSEL_W-1:0]  req_word_s;
  logic [1:0]         addr_unused_s;

  assign req_tag_s     = mem_address[31 -: S_TAG];
  assign req_index_s   = mem_address[S_OFFSET +: S_INDEX];
  assign req_word_s    = mem_address[2 +: WSEL_W];
  assign addr_unused_s = mem_address[1:0];

  // FSM and latched fill address
  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] fill_addr_r;
  logic [31:0] fill_addr_nxt_s;

  logic [S_TAG-1:0]   fill_tag_s;
  logic [S_INDEX-1:0] fill_index_s;

  assign fill_tag_s   = fill_addr_r[31 -: S_TAG];
  assign fill_index_s = fill_addr_r[S_OFFSET +: S_INDEX];

  // Way array interface
  logic [LINE_WIDTH-1:0] way_data_s [2];
  logic [S_TAG-1:0]      way_tag_s  [2];
  logic [1:0]            way_valid_s;
  logic [1:0]            way_fill_valid_s;
  logic [1:0]            way_fill_en_s;

  for (genvar w = 0; w < 2; w++) begin : g_way
    l1_icache_way #(
      .S_INDEX (S_INDEX),
      .S_TAG   (S_TAG)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .rd_index   (req_index_s),
      .rd_data    (way_data_s[w]),
      .rd_tag     (way_tag_s[w]),
      .rd_valid   (way_valid_s[w]),
      .fill_index (fill_index_s),
      .fill_en    (way_fill_en_s[w]),
      .fill_tag   (fill_tag_s),
      .fill_data  (pmem_rdata),
      .fill_valid (way_fill_valid_s[w])
    );
  end

  // LRU bit per set names the way to evict next
  logic [NUM_SETS-1:0] lru_r;

  logic [1:0]            hit_way_s;
  logic                  lookup_s;
  logic                  hit_s;
  logic                  miss_s;
  logic                  hit_sel_s;
  logic [LINE_WIDTH-1:0] hit_line_s;
  logic [31:0]           hit_word_s;
  logic                  victim_s;
  logic                  fill_en_s;

  assign hit_way_s[0] = way_valid_s[0] && (way_tag_s[0] == req_tag_s);
  assign hit_way_s[1] = way_valid_s[1] && (way_tag_s[1] == req_tag_s);

  // mem_read gates first so an unknown address cannot reach mem_resp while idle.
  assign lookup_s = mem_read && !rst && (state_r == IDLE);
  assign hit_s    = lookup_s && (hit_way_s != 2'b00);
  assign miss_s   = lookup_s && (hit_way_s == 2'b00);

  // Select the hitting way's line and the addressed word within it.
  always_comb begin
    hit_sel_s  = 1'b0;
    hit_line_s = way_data_s[0];
    if (hit_way_s[0]) begin
      hit_sel_s  = 1'b0;
      hit_line_s = way_data_s[0];
    end else begin
      hit_sel_s  = 1'b1;
      hit_line_s = way_data_s[1];
    end
    hit_word_s = hit_line_s[32 * int'(req_word_s) +: 32];
  end

  // Victim choice: an invalid way first (way 0 when both are), else the LRU way.
  always_comb begin
    victim_s = 1'b0;
    if (!way_fill_valid_s[0]) begin
      victim_s = 1'b0;
    end else if (!way_fill_valid_s[1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_r[fill_index_s];
    end
  end

  // A reset in the fill cycle suppresses the array write.
  assign fill_en_s        = !rst && (state_r == FETCH) && pmem_resp;
  assign way_fill_en_s[0] = fill_en_s && !victim_s;
  assign way_fill_en_s[1] = fill_en_s && victim_s;

  // LRU update: a hit points the set at the other way.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_r <= '0;
    end else if (hit_s) begin
      lru_r[req_index_s] <= ~hit_sel_s;
    end else begin
      lru_r <= lru_r;
    end
  end

  // Next-state and fill-address logic.
  always_comb begin
    state_nxt_s     = state_r;
    fill_addr_nxt_s = fill_addr_r;
    case (state_r)
      IDLE: begin
        if (miss_s) begin
          state_nxt_s     = FETCH;
          fill_addr_nxt_s = {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        end else begin
          state_nxt_s     = IDLE;
          fill_addr_nxt_s = fill_addr_r;
        end
      end
      FETCH: begin
        if (pmem_resp) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        fill_addr_nxt_s = 32'h0000_0000;
      end
    endcase
  end

  // State and fill-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      fill_addr_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      fill_addr_r <= fill_addr_nxt_s;
    end
  end

  assign mem_resp     = hit_s;
  assign mem_rdata    = hit_s ? hit_word_s : 32'h0000_0000;
  assign pmem_read    = !rst && (state_r == FETCH);
  assign pmem_address = pmem_read ? fill_addr_r : 32'h0000_0000;

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'h0000_0000;
      miss_count <= 32'h0000_0000;
    end else begin
      if (hit_s && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end else begin
        hit_count <= hit_count;
      end
      if (miss_s && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end else begin
        miss_count <= miss_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_icache.sv
// -----------------------------------------------------------------------------
// tb_l1_icache
// Directed self-checking bench for l1_icache. Inputs change on the falling
// clock edge and outputs are sampled 1 ns later, away from the rising edge.
// Fill lines are built so that word i of a line equals seed + i.
// -----------------------------------------------------------------------------
module tb_l1_icache;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_checks;
  int n_fail;

  l1_icache dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] make_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i*32 +: 32] = seed + i;
    end
    return l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b0;
    pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Miss on addr, serve the fill after lat cycles, then check the retry hit.
  task automatic miss_fill(input string name, input logic [31:0] addr,
                           input logic [31:0] seed, input int lat,
                           input logic [31:0] exp_rdata);
    bit found;
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = addr;
    #1;
    n_checks++;
    if (mem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_miss: mem_resp=%b expected 0", name, mem_resp);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #1;
      if (pmem_read === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s_pmem_read: pmem_read=%b expected 1 within 10 cycles", name, pmem_read);
    end
    n_checks++;
    if (pmem_address !== {addr[31:5], 5'b00000}) begin
      n_fail++;
      $display("FAIL %s_pmem_address: got %h expected %h", name, pmem_address, {addr[31:5], 5'b00000});
    end
    repeat (lat - 1) @(negedge clk);
    pmem_rdata = make_line(seed);
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (pmem_read !== 1'b1 || mem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_fetch_hold: pmem_read=%b mem_resp=%b expected 1/0", name, pmem_read, mem_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s_retry_hit: mem_resp=%b rdata=%h expected 1/%h", name, mem_resp, mem_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_read = 1'b1;
    mem_address = 32'h0000_0060;
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0 || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: resp=%b pread=%b paddr=%h rdata=%h expected all 0",
               mem_resp, pmem_read, pmem_address, mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0;
    mem_address = 'x;
    #1;
    n_checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL x_address_idle: mem_resp=%b pmem_read=%b expected 0/0", mem_resp, pmem_read);
    end
    @(negedge clk);
    mem_address = 32'h0;
  endtask

  task automatic test_cold_miss();
    do_reset();
    miss_fill("cold", 32'h0000_0060, 32'h0000_0013, 5, 32'h0000_0013);
  endtask

  task automatic test_word_select();
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h0000_007C;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'h0000_001A || pmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL word7: resp=%b rdata=%h pread=%b expected 1/0000001a/0", mem_resp, mem_rdata, pmem_read);
    end
    @(negedge clk);
    mem_address = 32'h0000_0068;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'h0000_0015) begin
      n_fail++;
      $display("FAIL word2: resp=%b rdata=%h expected 1/00000015", mem_resp, mem_rdata);
    end
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic test_conflict_lru();
    miss_fill("conf_a", 32'h0000_0000, 32'hA000_0000, 3, 32'hA000_0000);
    miss_fill("conf_b", 32'h0000_0200, 32'hB000_0000, 3, 32'hB000_0000);
    @(negedge clk);
    mem_address = 32'h0000_0000;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hA000_0000) begin
      n_fail++;
      $display("FAIL conf_a_hit: resp=%b rdata=%h expected 1/a0000000", mem_resp, mem_rdata);
    end
    miss_fill("conf_c", 32'h0000_0404, 32'hC000_0000, 2, 32'hC000_0001);
    @(negedge clk);
    mem_address = 32'h0000_0004;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hA000_0001) begin
      n_fail++;
      $display("FAIL conf_a_kept: resp=%b rdata=%h expected 1/a0000001", mem_resp, mem_rdata);
    end
    miss_fill("conf_b_evicted", 32'h0000_0200, 32'hB100_0000, 2, 32'hB100_0000);
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic test_redirect();
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h0000_0100;
    #1;
    n_checks++;
    if (mem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_miss: mem_resp=%b expected 0", mem_resp);
    end
    @(negedge clk);
    mem_address = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0100 || mem_resp !== 1'b0) begin
        n_fail++;
        $display("FAIL redir_hold: pread=%b paddr=%h resp=%b expected 1/00000100/0",
                 pmem_read, pmem_address, mem_resp);
      end
      @(negedge clk);
    end
    pmem_rdata = make_line(32'hD000_0000);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #1;
    n_checks++;
    if (mem_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_new_miss: mem_resp=%b expected 0", mem_resp);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0300) begin
      n_fail++;
      $display("FAIL redir_new_fetch: pread=%b paddr=%h expected 1/00000300", pmem_read, pmem_address);
    end
    pmem_rdata = make_line(32'hE000_0000);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hE000_0000) begin
      n_fail++;
      $display("FAIL redir_retry: resp=%b rdata=%h expected 1/e0000000", mem_resp, mem_rdata);
    end
    @(negedge clk);
    mem_address = 32'h0000_0100;
    #1;
    n_checks++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hD000_0000) begin
      n_fail++;
      $display("FAIL redir_old_line: resp=%b rdata=%h expected 1/d0000000", mem_resp, mem_rdata);
    end
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 32'h0000_0100;
    @(negedge clk);
    #1;
    n_checks++;
    if (pmem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL rmf_fetch: pmem_read=%b expected 1", pmem_read);
    end
    rst = 1'b1;
    pmem_rdata = make_line(32'hF000_0000);
    pmem_resp = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0;
    #1;
    n_checks++;
    if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
      n_fail++;
      $display("FAIL rmf_abort: pread=%b paddr=%h expected 0/00000000", pmem_read, pmem_address);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #1;
    n_checks++;
    if (pmem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rmf_late_resp: pmem_read=%b expected 0", pmem_read);
    end
    miss_fill("rmf_refetch", 32'h0000_0100, 32'h1111_0000, 2, 32'h1111_0000);
    @(negedge clk);
    mem_read = 1'b0;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: hit=%0d miss=%0d expected 0/0", hit_count, miss_count);
    end
    miss_fill("stats", 32'h0000_0060, 32'h0000_0013, 3, 32'h0000_0013);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      mem_address = 32'h0000_0060 + 32'(i * 4);
    end
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    n_checks++;
    if (hit_count !== 32'd4 || miss_count !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_counts: hit=%0d miss=%0d expected 4/1", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_address = 32'h0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_cold_miss();
    test_word_select();
    test_conflict_lru();
    test_redirect();
    test_reset_mid_fetch();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
